fsm_xy_driver: RTL
==================

Name: fsm_xy_driver

Overview:
- Stimulus-side counterpart of the team's 4-state x/y practice FSM (states SA/SB/SC/DA-style SA..SD, inputs x,y, registered output q).
- Accepts a target-state request over a valid/ready handshake and drives x,y each cycle along the shortest path to that state.
- Keeps a cycle-accurate model of the FSM and checks the FSM's q output against the model, flagging mismatches.
- Sits next to the FSM on the same Clk/Rst. Its x,y feed the FSM and the FSM's q returns as q_in.

Parameters:
- ERR_W, 8, width of the saturating mismatch counter.
- CHECK_EN, 1, when 0 the err and err_cnt outputs stay at 0.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- req_valid  input  1  target request valid.
- req_state  input  2  target state: 0=SA, 1=SB, 2=SC, 3=SD.
- req_ready  output  1  high only in IDLE.
- x  output  1  FSM input x (combinational from model state, mode and target).
- y  output  1  FSM input y.
- q_in  input  1  FSM registered output q.
- model_state  output  2  driver's model of the FSM state.
- done  output  1  one-cycle pulse when the model reaches the target.
- steps  output  2  number of moves taken by the last completed request (0..2).
- err  output  1  sticky q-mismatch flag.
- err_cnt  output  ERR_W  saturating count of q mismatches.

Behaviour:
- Reset values (Rst high at an edge): mode=IDLE, model_state=SA, exp_q=1, done=0, steps=0, err=0, err_cnt=0. Reset mid-request abandons the request and issues no done.
- FSM model, applied every non-reset edge using the x,y driven that cycle:
  - SA -> SB if x|y, else SC.
  - SB -> SC if y, else SB.
  - SC -> SA if x&y; SC if ~x&y; SD if ~y.
  - SD -> SA unconditionally.
- q model: qval(SA)=1, qval(SB)=0, qval(SC)=0, qval(SD)=1. On every non-reset edge, exp_q <= qval(model_state before the edge).
- Driver modes: IDLE, DRIVE, DONE.
  - IDLE: req_ready=1. On req_valid and target == model_state, go to DONE with steps=0. On req_valid otherwise, latch the target, clear the step count and go to DRIVE.
  - DRIVE: drive the path vector for (model_state, target) and increment the step count. When the next model state equals the target, go to DONE.
  - DONE: done=1 for exactly this cycle, steps updated, drive the idle vector, return to IDLE. req_ready=0 in this cycle.
- Path vectors, written as (x,y) then the resulting state:
  - From SA: SB by 10; SC by 00; SD by 00 then 00; SA by 00 then 11 (only reachable when target != model, which never happens for SA->SA).
  - From SB: SC by 01; SA by 01 then 11; SD by 01 then 00.
  - From SC: SA by 11; SD by 00; SB by 11 then 10.
  - From SD: SA by 00; SB by 00 then 10; SC by 00 then 00.
- Idle vectors (used in IDLE and DONE): SB 00 (holds); SC 01 (holds); SA 00 (goes to SC); SD 00 (goes to SA). The model keeps tracking while idle, so an untouched FSM parks in SC.
- Check: every cycle with Rst low and CHECK_EN=1, compare q_in with exp_q.
  - On mismatch: err <= 1 (sticky until Rst); err_cnt increments and saturates at all-ones.
  - A match in the same cycle leaves both unchanged.
- A req_valid asserted while not in IDLE is ignored (not ready). The requester must hold the request until it is accepted.

Decomposition:
- Shared package fsm_xy_pkg holds:
  - the state encoding constants SA..SD and the 2-bit state typedef;
  - the qval function and the next-state function (the same model the FSM implements);
  - the mode typedef.
- One sub-module, fsm_xy_path: combinational (model_state, target, active) -> (x, y). It holds both the path table and the idle table.
- Checker and counters stay in the top module.

Test Plan:
- Reset, then no requests for 3 cycles -> model_state SA, SC, SC; x,y = 00, 01, 01; err=0 with a correct FSM attached.
- From SC, request SA -> accepted, x,y=11 for one cycle, model_state=SA, then a done pulse with steps=1; next cycle q_in=0 matches exp_q=qval(SC)=0.
- From SC, request SB -> x,y=11 then 10, model SA then SB, done with steps=2, err=0.
- From SB, request SB (idle in SB after a prior request) -> done the cycle after acceptance, steps=0, x,y stays 00.
- Force q_in inverted for 3 cycles -> err=1, err_cnt=3. Assert Rst -> err=0, err_cnt=0. With ERR_W=2 and 5 forced mismatches -> err_cnt=3.
- Assert Rst in the first DRIVE cycle of an SD request from SB -> no done, model_state=SA, req_ready=1 after reset, and a new request completes normally.

Source files
------------

// File: rtl/fsm_xy_pkg.sv
// fsm_xy_pkg
//   Shared definitions for the x/y practice FSM and the driver that exercises it.
//   Contents:
//     state_t / SA..SD  2-bit FSM state encoding
//     mode_t            driver sequencing modes
//     qval()            registered-output value produced from a given state
//     next_state()      FSM transition function on inputs x, y
package fsm_xy_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SA = 2'd0;
  localparam state_t SB = 2'd1;
  localparam state_t SC = 2'd2;
  localparam state_t SD = 2'd3;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_DRIVE = 2'd1,
    MODE_DONE  = 2'd2
  } mode_t;

  // q is high in SA and SD, low in SB and SC.
  function automatic logic qval(input state_t s);
    return (s == SA) || (s == SD);
  endfunction

  function automatic state_t next_state(input state_t s, input logic x, input logic y);
    state_t n;
    n = SA;
    case (s)
      SA: n = (x | y) ? SB : SC;
      SB: n = y ? SC : SB;
      SC: begin
        if (!y)     n = SD;
        else if (x) n = SA;
        else        n = SC;
      end
      default: n = SA;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fsm_xy_path.sv
// fsm_xy_path
//   Combinational x/y selection for the driver.
//   When active, produces the first move of the shortest path from the current
//   model state toward the target; repeated each cycle this walks the whole
//   path, because every two-move path passes through a state whose own first
//   move completes it. When inactive, produces the idle vector for the state.
//   Ports:
//     state_i   current model state
//     target_i  requested target state
//     active_i  1 = follow path table, 0 = idle table
//     x_o, y_o  FSM inputs for this cycle
module fsm_xy_path
  import fsm_xy_pkg::*;
(
  input  state_t state_i,
  input  state_t target_i,
  input  logic   active_i,
  output logic   x_o,
  output logic   y_o
);

  logic [1:0] path_xy;
  logic [1:0] idle_xy;

  // Path table: {x,y} of the first move from state_i toward target_i.
  // Diagonal entries (state == target) are only hit if the model drifted onto
  // the target while the request was being accepted; they pick a move that
  // either holds the state or starts a loop back to it.
  always_comb begin
    path_xy = 2'b00;
    case (state_i)
      SA: begin
        case (target_i)
          SB:      path_xy = 2'b10;
          default: path_xy = 2'b00;  // SC directly, SD and SA via SC
        endcase
      end
      SB: begin
        case (target_i)
          SB:      path_xy = 2'b00;  // hold
          default: path_xy = 2'b01;  // all other targets pass through SC
        endcase
      end
      SC: begin
        case (target_i)
          SA:      path_xy = 2'b11;
          SB:      path_xy = 2'b11;  // via SA
          SC:      path_xy = 2'b01;  // hold
          default: path_xy = 2'b00;  // SD
        endcase
      end
      default: path_xy = 2'b00;      // SD always exits to SA
    endcase
  end

  // Idle table: SB and SC hold; SA falls to SC; SD returns to SA.
  always_comb begin
    idle_xy = 2'b00;
    if (state_i == SC) idle_xy = 2'b01;
  end

  assign {x_o, y_o} = active_i ? path_xy : idle_xy;

endmodule

// File: rtl/fsm_xy_driver.sv
// fsm_xy_driver
//   Stimulus/checker companion for the x/y practice FSM. Accepts a target
//   state over valid/ready, steers x,y along the shortest path to it, tracks
//   the FSM with a cycle-accurate model and checks the returned q.
//   Ports:
//     Clk, Rst             clock (rising edge), synchronous active-high reset
//     req_valid/req_state  target request; req_ready high only in IDLE
//     x, y                 FSM inputs (combinational from registered state)
//     q_in                 FSM registered output
//     model_state          driver's copy of the FSM state
//     done, steps          completion pulse and move count of last request
//     err, err_cnt         sticky mismatch flag and saturating mismatch count
//
//   mode       | meaning
//   -----------+-----------------------------------------------------------
//   MODE_IDLE  | ready for a request; idle vector keeps the model parked
//   MODE_DRIVE | walking toward target_q, one move per cycle
//   MODE_DONE  | done pulse cycle; idle vector; not ready
module fsm_xy_driver
  import fsm_xy_pkg::*;
#(
  parameter int ERR_W    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req_valid,
  input  logic [1:0]       req_state,
  output logic             req_ready,
  output logic             x,
  output logic             y,
  input  logic             q_in,
  output logic [1:0]       model_state,
  output logic             done,
  output logic [1:0]       steps,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  mode_t            mode_q;
  state_t           model_q;
  state_t           model_d;
  state_t           target_q;
  logic             expq_q;
  logic [1:0]       step_q;
  logic [1:0]       step_inc;
  logic [1:0]       steps_q;
  logic             done_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             mismatch;

  fsm_xy_path u_path (
    .state_i  (model_q),
    .target_i (target_q),
    .active_i (mode_q == MODE_DRIVE),
    .x_o      (x),
    .y_o      (y)
  );

  // The model advances on whatever vector is driven, in every mode.
  assign model_d  = next_state(model_q, x, y);
  assign mismatch = CHECK_EN && (q_in != expq_q);
  // Paths are at most two moves; saturate so a stray loop cannot wrap to 0.
  assign step_inc = (step_q == 2'd3) ? 2'd3 : step_q + 2'd1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode_q    <= MODE_IDLE;
      model_q   <= SA;
      target_q  <= SA;
      expq_q    <= 1'b1;
      step_q    <= 2'd0;
      steps_q   <= 2'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      model_q <= model_d;
      expq_q  <= qval(model_q);
      done_q  <= 1'b0;

      if (mismatch) begin
        err_q <= 1'b1;
        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + ERR_W'(1);
      end

      case (mode_q)
        MODE_IDLE: begin
          if (req_valid) begin
            if (req_state == model_q) begin
              mode_q  <= MODE_DONE;
              done_q  <= 1'b1;
              steps_q <= 2'd0;
            end else begin
              mode_q   <= MODE_DRIVE;
              target_q <= req_state;
              step_q   <= 2'd0;
            end
          end
        end
        MODE_DRIVE: begin
          step_q <= step_inc;
          if (model_d == target_q) begin
            mode_q  <= MODE_DONE;
            done_q  <= 1'b1;
            steps_q <= step_inc;
          end
        end
        default: mode_q <= MODE_IDLE;
      endcase
    end
  end

  assign req_ready   = (mode_q == MODE_IDLE);
  assign model_state = model_q;
  assign done        = done_q;
  assign steps       = steps_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule
